uart_rx_deser: RTL
==================

Name: uart_rx_deser

Overview:
- 8N1 UART receiver stage that consumes the already double-flop-synchronised serial RX line and turns it into parallel bytes.
- Hands each byte to the ALU command path through a valid/ready register slice.
- Sits between the board-level RX synchroniser and the command decoder inside top; baud timing is derived from the same ClkFreq/BaudRate pair top receives.
- Reports framing errors and overruns as one-cycle pulses.

Parameters:
- ClkFreq, 18000000, system clock frequency in Hz.
- BaudRate, 115200, serial bit rate.
- ClksPerBit, ClkFreq/BaudRate (derived localparam, integer-truncated; 156 at defaults), clock cycles per bit; elaboration error if < 4.

Ports:
- clk_i  input  1  system clock, single clock domain.
- rst_i  input  1  reset, asynchronous, active-high.
- rx_i  input  1  synchronised serial input, idle high.
- data_o  output  8  received byte, LSB = first data bit.
- valid_o  output  1  data_o holds an unconsumed byte.
- ready_i  input  1  consumer accepts data_o when valid_o && ready_i.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  one-cycle pulse: byte completed while output slot still full.
- busy_o  output  1  high whenever state != IDLE.

Behaviour:
- Reset: state IDLE, bit counter 0, baud counter 0, shift register 0; data_o=0, valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0. Reset mid-frame aborts the frame with no pulses; a pending output byte is lost.
- Baud counter: width $clog2(ClksPerBit), counts 0..ClksPerBit-1, then wraps to 0 and produces a tick.
- States:
  - IDLE: rx_i==0 -> START, baud counter cleared.
  - START: after ClksPerBit/2 cycles (mid start bit), sample rx_i. If 1, this is a false start -> IDLE with no pulse. If 0 -> DATA, bit index 0, baud counter cleared.
  - DATA: on each tick, shift rx_i in LSB-first. After the 8th bit -> STOP (or PARITY when enabled).
  - STOP: on tick, sample rx_i.
    - 1: the byte completes -> IDLE.
    - 0: frame_err_o pulses for 1 cycle, byte discarded -> BREAK.
  - BREAK: wait for rx_i==1, then -> IDLE. Prevents a held-low line from being taken as a new start bit.
- Output slice (sequential):
  - Byte completes while valid_o==0, or while valid_o && ready_i in the same cycle: data_o loads the new byte and valid_o=1 on the next cycle. The simultaneous case does not pulse overrun_o.
  - Byte completes while valid_o && !ready_i: the new byte is dropped, data_o is unchanged, and overrun_o pulses 1 cycle.
  - valid_o && ready_i with no completion: valid_o=0 next cycle; data_o holds its last value.
  - data_o must stay stable while valid_o && !ready_i.
- Latency: valid_o rises 1 cycle after the mid-stop-bit sample, i.e. about 9.5 bit periods + 1 clk after the start-bit falling edge.
- Receiver is ready for the next start bit in the cycle after the stop sample, so back-to-back frames with a zero-length idle gap are received without loss.

Optional Feature:
- UART_RX_PARITY_EN defined: frame is 8E1. A PARITY state is inserted after DATA and samples one extra bit on tick.
  - If the XOR of the 8 data bits and the parity bit is 1, the byte is discarded, an extra output parity_err_o (1 bit, reset 0) pulses 1 cycle, and the stop bit is still checked normally.
  - latency +1 bit period.
- Undefined: 8N1 only; no PARITY state and no parity_err_o port.

Test Plan (ClkFreq=1600, BaudRate=100 -> ClksPerBit=16; ready_i=1 unless stated):
- Send 0xA5 8N1 -> valid_o high exactly 1 cycle with data_o=0xA5; frame_err_o and overrun_o stay 0; busy_o returns 0.
- 3-cycle low glitch on idle rx_i -> FSM returns to IDLE after the mid-start sample; valid_o and frame_err_o never assert.
- Send 0x3C with stop bit driven 0, then hold rx_i low for 40 cycles, then high, then send 0x81 -> frame_err_o pulses once and no byte is delivered for the bad frame; 0x81 is then received correctly.
- ready_i=0, send 0x11 then 0x22 back-to-back -> data_o=0x11 held with valid_o=1; overrun_o pulses once at the 0x22 stop sample; after ready_i=1, one handshake yields 0x11 and valid_o drops.
- Back-to-back 0x00, 0xFF, 0x55 with zero idle gap -> three valid_o handshakes in order, with no errors.
- Assert rst_i mid-DATA of 0x96, release, send 0x4B -> all outputs 0 during reset; only 0x4B is delivered. With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err_o pulses, no byte is delivered.

Source files
------------

// File: rtl/uart_rx_deser.sv
// uart_rx_deser: 8N1 UART receiver with a valid/ready output register slice.
// Ports: clk_i, rst_i (async, active-high); rx_i serial in (idle high);
//   data_o/valid_o/ready_i byte handshake; frame_err_o, overrun_o pulses;
//   busy_o while a frame is in progress.
// Define UART_RX_PARITY_EN for 8E1 framing, which adds the parity_err_o pulse.
module uart_rx_deser #(
  parameter int ClkFreq  = 18000000,
  parameter int BaudRate = 115200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err_o,
`endif
  output logic       busy_o
);

  localparam int ClksPerBit = ClkFreq / BaudRate;
  localparam int CW = $clog2(ClksPerBit);
  localparam logic [CW-1:0] CntMax = CW'(ClksPerBit - 1);
  localparam logic [CW-1:0] CntHalf = CW'(ClksPerBit / 2 - 1);

  if (ClksPerBit < 4) begin : g_bad_cfg
    $error("uart_rx_deser: ClksPerBit must be >= 4");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PAR,
`endif
    S_STOP,
    S_BRK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tick;
  logic          done;
  logic          ferr;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
  logic          perr;
`endif

  assign tick   = (cnt_q == CntMax);
  assign busy_o = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    done    = 1'b0;
    ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr      = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_i) state_d = S_START;
      end
      S_START: begin
        // Sample the middle of the start bit to reject glitches.
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_i ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shreg_d = {rx_i, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PAR: begin
        if (tick) begin
          cnt_d     = '0;
          par_bad_d = ^{shreg_q, rx_i};
          perr      = par_bad_d;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          cnt_d = '0;
          if (rx_i) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            done = !par_bad_q;
`else
            done = 1'b1;
`endif
          end else begin
            ferr    = 1'b1;
            state_d = S_BRK;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BRK: begin
        // Hold off until the line returns high so a held-low
        // line is not taken as a fresh start bit.
        cnt_d = '0;
        if (rx_i) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_o <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      frame_err_o <= ferr;
      overrun_o   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_o <= perr;
`endif
      // Output slice: a new byte may replace one being consumed
      // this cycle; otherwise a full slot drops the new byte.
      if (done) begin
        if (!valid_o || ready_i) begin
          data_o  <= shreg_q;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
